// File: rtl/sms_arb_pkg.sv
// Shared AHB-lite encodings and the bus-owner type used by the SMS bank arbiter.
package sms_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_M0   = 2'b01,
      OWN_M1   = 2'b10
   } owner_e;

   // SEQ and BUSY both continue a burst, so either one holds the bus lock.
   function automatic logic is_burst_cont(input logic [1:0] htrans);
      return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
   endfunction

endpackage

// File: rtl/sms_arb_grant.sv
// Combinational grant: burst lock, then M1 starvation override, then fixed priority M0 > M1.
module sms_arb_grant
   import sms_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic [1:0] req,
   input  logic [1:0] hsel,
   input  logic [1:0] htrans0,
   input  logic [1:0] htrans1,
   input  owner_e     last_owner,
   input  logic [3:0] wait_cnt,
   output owner_e     grant
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic lock0_s;
   logic lock1_s;

   assign lock0_s = (last_owner == OWN_M0) && hsel[0] && is_burst_cont(htrans0);
   assign lock1_s = (last_owner == OWN_M1) && hsel[1] && is_burst_cont(htrans1);

   // Priority chain evaluated every cycle; the top level decides when it takes effect.
   always_comb begin
      grant = OWN_NONE;
      if (lock0_s) begin
         grant = OWN_M0;
      end else if (lock1_s) begin
         grant = OWN_M1;
      end else if (req[1] && (wait_cnt == STARVE_LIM)) begin
         grant = OWN_M1;
      end else if (req[0]) begin
         grant = OWN_M0;
      end else if (req[1]) begin
         grant = OWN_M1;
      end else begin
         grant = OWN_NONE;
      end
   end

endmodule

// File: rtl/sms_bank_ahb_arb.sv
// Two-master AHB-lite arbiter in front of one SMS SRAM bank: M0 (CPU) has priority,
// M1 (DMA) is protected by a starvation counter, bursts keep the bus until they end.
module sms_bank_ahb_arb
   import sms_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic        mem_hclk,
   input  logic        mem_hrst_b,
   input  logic        m0_hsel,
   input  logic [31:0] m0_haddr,
   input  logic [1:0]  m0_htrans,
   input  logic        m0_hwrite,
   input  logic [2:0]  m0_hsize,
   input  logic [3:0]  m0_hprot,
   input  logic [31:0] m0_hwdata,
   output logic [31:0] m0_hrdata,
   output logic        m0_hready_resp,
   output logic [1:0]  m0_hresp,
   input  logic        m1_hsel,
   input  logic [31:0] m1_haddr,
   input  logic [1:0]  m1_htrans,
   input  logic        m1_hwrite,
   input  logic [2:0]  m1_hsize,
   input  logic [3:0]  m1_hprot,
   input  logic [31:0] m1_hwdata,
   output logic [31:0] m1_hrdata,
   output logic        m1_hready_resp,
   output logic [1:0]  m1_hresp,
   output logic        s_hsel,
   output logic [31:0] s_haddr,
   output logic [1:0]  s_htrans,
   output logic        s_hwrite,
   output logic [2:0]  s_hsize,
   output logic [3:0]  s_hprot,
   output logic [31:0] s_hwdata,
   output logic        s_hready,
   input  logic [31:0] s_hrdata,
   input  logic        s_hready_resp,
   input  logic [1:0]  s_hresp,
   output logic        arb_idle
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic       req0_s;
   logic       req1_s;
   owner_e     raw_grant_s;
   owner_e     grant_s;
   logic [1:0] gnt_trans_s;
   owner_e     last_owner_r;
   owner_e     dp_owner_r;
   owner_e     pend_owner_r;
   logic [3:0] wait_cnt_r;

   assign req0_s   = m0_hsel & m0_htrans[1];
   assign req1_s   = m1_hsel & m1_htrans[1];
   assign s_hready = s_hready_resp;
   assign arb_idle = ~req0_s & ~req1_s & (dp_owner_r == OWN_NONE);

   sms_arb_grant #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .req        ({req1_s, req0_s}),
      .hsel       ({m1_hsel, m0_hsel}),
      .htrans0    (m0_htrans),
      .htrans1    (m1_htrans),
      .last_owner (last_owner_r),
      .wait_cnt   (wait_cnt_r),
      .grant      (raw_grant_s)
   );

   // An address presented during a bank wait state stays on the bus until accepted.
   always_comb begin
      grant_s = raw_grant_s;
      if ((pend_owner_r == OWN_M0) && req0_s) begin
         grant_s = OWN_M0;
      end else if ((pend_owner_r == OWN_M1) && req1_s) begin
         grant_s = OWN_M1;
      end else begin
         grant_s = raw_grant_s;
      end
   end

   // Address/control mux toward the bank; an ungranted bus drives IDLE.
   always_comb begin
      s_hsel      = 1'b0;
      s_haddr     = 32'h0000_0000;
      s_htrans    = HTRANS_IDLE;
      s_hwrite    = 1'b0;
      s_hsize     = 3'b000;
      s_hprot     = 4'b0000;
      gnt_trans_s = HTRANS_IDLE;
      case (grant_s)
         OWN_M0: begin
            s_hsel      = m0_hsel;
            s_haddr     = m0_haddr;
            s_htrans    = m0_htrans;
            s_hwrite    = m0_hwrite;
            s_hsize     = m0_hsize;
            s_hprot     = m0_hprot;
            gnt_trans_s = m0_htrans;
         end
         OWN_M1: begin
            s_hsel      = m1_hsel;
            s_haddr     = m1_haddr;
            s_htrans    = m1_htrans;
            s_hwrite    = m1_hwrite;
            s_hsize     = m1_hsize;
            s_hprot     = m1_hprot;
            gnt_trans_s = m1_htrans;
         end
         default: begin
            s_hsel      = 1'b0;
            gnt_trans_s = HTRANS_IDLE;
         end
      endcase
   end

   // Write data follows whoever owns the data phase.
   always_comb begin
      s_hwdata = 32'h0000_0000;
      case (dp_owner_r)
         OWN_M0:  s_hwdata = m0_hwdata;
         OWN_M1:  s_hwdata = m1_hwdata;
         default: s_hwdata = 32'h0000_0000;
      endcase
   end

   // Ownership registers: load on address acceptance, remember a stalled grant otherwise.
   always_ff @(posedge mem_hclk or negedge mem_hrst_b) begin
      if (!mem_hrst_b) begin
         last_owner_r <= OWN_NONE;
         dp_owner_r   <= OWN_NONE;
         pend_owner_r <= OWN_NONE;
      end else if (s_hready_resp) begin
         last_owner_r <= grant_s;
         // BUSY keeps the burst lock but carries no data phase.
         dp_owner_r   <= (gnt_trans_s == HTRANS_BUSY) ? OWN_NONE : grant_s;
         pend_owner_r <= OWN_NONE;
      end else begin
         pend_owner_r <= grant_s;
      end
   end

   // M1 wait counter: saturates at the starvation limit, clears on M1 acceptance or no request.
   always_ff @(posedge mem_hclk or negedge mem_hrst_b) begin
      if (!mem_hrst_b) begin
         wait_cnt_r <= 4'd0;
      end else if (req1_s && !(s_hready_resp && (grant_s == OWN_M1))) begin
         if (wait_cnt_r < STARVE_LIM) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= STARVE_LIM;
         end
      end else begin
         wait_cnt_r <= 4'd0;
      end
   end

   // Response steering to M0: data-phase owner sees the bank, a losing requester is stalled.
   always_comb begin
      m0_hrdata      = 32'h0000_0000;
      m0_hresp       = HRESP_OKAY;
      m0_hready_resp = 1'b1;
      if (dp_owner_r == OWN_M0) begin
         m0_hrdata      = s_hrdata;
         m0_hresp       = s_hresp;
         m0_hready_resp = s_hready_resp;
      end else if (req0_s && (grant_s != OWN_M0)) begin
         m0_hready_resp = 1'b0;
      end else if (req0_s) begin
         m0_hready_resp = s_hready_resp;
      end else begin
         m0_hready_resp = 1'b1;
      end
   end

   // Response steering to M1, same rules as M0.
   always_comb begin
      m1_hrdata      = 32'h0000_0000;
      m1_hresp       = HRESP_OKAY;
      m1_hready_resp = 1'b1;
      if (dp_owner_r == OWN_M1) begin
         m1_hrdata      = s_hrdata;
         m1_hresp       = s_hresp;
         m1_hready_resp = s_hready_resp;
      end else if (req1_s && (grant_s != OWN_M1)) begin
         m1_hready_resp = 1'b0;
      end else if (req1_s) begin
         m1_hready_resp = s_hready_resp;
      end else begin
         m1_hready_resp = 1'b1;
      end
   end

endmodule

// File: tb/tb_sms_bank_ahb_arb.sv
// Directed bench for the two-master SMS bank arbiter with hand-computed expectations.
module tb_sms_bank_ahb_arb;

   logic        mem_hclk;
   logic        mem_hrst_b;
   logic        m0_hsel, m1_hsel;
   logic [31:0] m0_haddr, m1_haddr;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite;
   logic [2:0]  m0_hsize, m1_hsize;
   logic [3:0]  m0_hprot, m1_hprot;
   logic [31:0] m0_hwdata, m1_hwdata;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic        m0_hready_resp, m1_hready_resp;
   logic [1:0]  m0_hresp, m1_hresp;
   logic        s_hsel;
   logic [31:0] s_haddr;
   logic [1:0]  s_htrans;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [3:0]  s_hprot;
   logic [31:0] s_hwdata;
   logic        s_hready;
   logic [31:0] s_hrdata;
   logic        s_hready_resp;
   logic [1:0]  s_hresp;
   logic        arb_idle;

   int n_checks = 0;
   int n_errors = 0;

   sms_bank_ahb_arb #(.STARVE_MAX(8)) dut (
      .mem_hclk(mem_hclk), .mem_hrst_b(mem_hrst_b),
      .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
      .m0_hsize(m0_hsize), .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
      .m0_hready_resp(m0_hready_resp), .m0_hresp(m0_hresp),
      .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
      .m1_hsize(m1_hsize), .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
      .m1_hready_resp(m1_hready_resp), .m1_hresp(m1_hresp),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
      .s_hsize(s_hsize), .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hready(s_hready),
      .s_hrdata(s_hrdata), .s_hready_resp(s_hready_resp), .s_hresp(s_hresp),
      .arb_idle(arb_idle)
   );

   initial mem_hclk = 1'b0;
   always #5 mem_hclk = ~mem_hclk;

   // Count one comparison and report it if observed differs from expected.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic m0_drv(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
      m0_hsel = sel; m0_htrans = tr; m0_hwrite = wr; m0_haddr = a;
   endtask

   task automatic m1_drv(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
      m1_hsel = sel; m1_htrans = tr; m1_hwrite = wr; m1_haddr = a;
   endtask

   task automatic bank(input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
      s_hready_resp = rdy; s_hresp = resp; s_hrdata = rd;
   endtask

   // Advance to just after the next rising edge; inputs are driven there, checks 2 ns later.
   task automatic next_cycle();
      @(posedge mem_hclk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic all_idle();
      m0_drv(1'b0, 2'b00, 1'b0, 32'h0);
      m1_drv(1'b0, 2'b00, 1'b0, 32'h0);
      bank(1'b1, 2'b00, 32'h0);
   endtask

   initial begin
      mem_hrst_b = 1'b0;
      m0_hsize = 3'b010; m1_hsize = 3'b010;
      m0_hprot = 4'b0011; m1_hprot = 4'b0001;
      m0_hwdata = 32'h0; m1_hwdata = 32'h0;
      all_idle();
      #12;
      // Reset state
      check_val("rst_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      check_val("rst_m0_hresp", {30'd0, m0_hresp}, 32'd0);
      check_val("rst_m0_hrdata", m0_hrdata, 32'h0);
      check_val("rst_m1_hready", {31'd0, m1_hready_resp}, 32'd1);
      check_val("rst_s_hsel", {31'd0, s_hsel}, 32'd0);
      check_val("rst_s_htrans", {30'd0, s_htrans}, 32'd0);
      check_val("rst_s_hwdata", s_hwdata, 32'h0);
      check_val("rst_arb_idle", {31'd0, arb_idle}, 32'd1);
      mem_hrst_b = 1'b1;

      // Simultaneous requests: M0 wins cycle 0, M1 follows in cycle 1
      next_cycle();
      m0_drv(1'b1, 2'b10, 1'b0, 32'h100);
      m1_drv(1'b1, 2'b10, 1'b0, 32'h200);
      settle();
      check_val("sim_c0_s_haddr", s_haddr, 32'h100);
      check_val("sim_c0_s_hsize", {29'd0, s_hsize}, 32'd2);
      check_val("sim_c0_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      check_val("sim_c0_m1_hready", {31'd0, m1_hready_resp}, 32'd0);
      next_cycle();
      m0_drv(1'b0, 2'b00, 1'b0, 32'h0);
      bank(1'b1, 2'b00, 32'h1111_0100);
      settle();
      check_val("sim_c1_m0_hrdata", m0_hrdata, 32'h1111_0100);
      check_val("sim_c1_s_haddr", s_haddr, 32'h200);
      check_val("sim_c1_m1_hready", {31'd0, m1_hready_resp}, 32'd1);
      check_val("sim_c1_m1_hrdata", m1_hrdata, 32'h0);
      next_cycle();
      m1_drv(1'b0, 2'b00, 1'b0, 32'h0);
      bank(1'b1, 2'b00, 32'h2222_0200);
      settle();
      check_val("sim_c2_m1_hrdata", m1_hrdata, 32'h2222_0200);
      check_val("sim_c2_m0_hrdata", m0_hrdata, 32'h0);
      check_val("sim_c2_arb_idle", {31'd0, arb_idle}, 32'd0);
      next_cycle();
      all_idle();
      settle();
      check_val("sim_c3_arb_idle", {31'd0, arb_idle}, 32'd1);

      // Burst lock: M1 INCR4, M0 requests from beat 2 and waits until the burst ends
      next_cycle();
      m1_drv(1'b1, 2'b10, 1'b0, 32'h300);
      settle();
      check_val("lock_b1_s_haddr", s_haddr, 32'h300);
      check_val("lock_b1_s_hprot", {28'd0, s_hprot}, 32'd1);
      for (int b = 1; b < 4; b++) begin
         next_cycle();
         m1_drv(1'b1, 2'b11, 1'b0, 32'h300 + 32'(4 * b));
         m0_drv(1'b1, 2'b10, 1'b0, 32'h500);
         settle();
         check_val("lock_seq_s_haddr", s_haddr, 32'h300 + 32'(4 * b));
         check_val("lock_seq_m0_hready", {31'd0, m0_hready_resp}, 32'd0);
      end
      next_cycle();
      m1_drv(1'b0, 2'b00, 1'b0, 32'h0);
      settle();
      check_val("lock_end_s_haddr", s_haddr, 32'h500);
      check_val("lock_end_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      next_cycle();
      all_idle();
      next_cycle();

      // Starvation: M1 waits 8 cycles behind back-to-back M0, wins on the 9th
      for (int c = 0; c < 9; c++) begin
         m0_drv(1'b1, 2'b10, 1'b0, 32'h600);
         m1_drv(1'b1, 2'b10, 1'b0, 32'h700);
         settle();
         if (c < 8) begin
            check_val("starve_wait_s_haddr", s_haddr, 32'h600);
            check_val("starve_wait_m1_hready", {31'd0, m1_hready_resp}, 32'd0);
         end else begin
            check_val("starve_win_s_haddr", s_haddr, 32'h700);
            check_val("starve_win_m1_hready", {31'd0, m1_hready_resp}, 32'd1);
         end
         next_cycle();
      end
      settle();
      check_val("starve_after_s_haddr", s_haddr, 32'h600);
      next_cycle();
      all_idle();
      next_cycle();

      // Write data steering while M0 is stalled by a bank wait state
      m0_hwdata = 32'h1234_5678;
      m1_drv(1'b1, 2'b10, 1'b1, 32'h40);
      settle();
      check_val("wr_c0_s_hwrite", {31'd0, s_hwrite}, 32'd1);
      check_val("wr_c0_s_haddr", s_haddr, 32'h40);
      next_cycle();
      m1_drv(1'b0, 2'b00, 1'b0, 32'h0);
      m1_hwdata = 32'hDEAD_BEEF;
      m0_drv(1'b1, 2'b10, 1'b0, 32'h80);
      bank(1'b0, 2'b00, 32'h5555_5555);
      settle();
      check_val("wr_c1_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
      check_val("wr_c1_m0_hrdata", m0_hrdata, 32'h0);
      check_val("wr_c1_m0_hready", {31'd0, m0_hready_resp}, 32'd0);
      next_cycle();
      bank(1'b1, 2'b00, 32'h0);
      settle();
      check_val("wr_c2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
      check_val("wr_c2_s_haddr", s_haddr, 32'h80);
      check_val("wr_c2_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      next_cycle();
      m0_drv(1'b0, 2'b00, 1'b0, 32'h0);
      bank(1'b1, 2'b00, 32'hCAFE_0080);
      settle();
      check_val("wr_c3_m0_hrdata", m0_hrdata, 32'hCAFE_0080);
      check_val("wr_c3_s_hwdata", s_hwdata, 32'h1234_5678);
      next_cycle();
      all_idle();
      next_cycle();

      // ERROR routing: two-cycle ERROR reaches only M0
      m0_drv(1'b1, 2'b10, 1'b1, 32'h900);
      settle();
      next_cycle();
      m0_drv(1'b0, 2'b00, 1'b0, 32'h0);
      m1_drv(1'b1, 2'b10, 1'b0, 32'hA00);
      bank(1'b0, 2'b01, 32'h0);
      settle();
      check_val("err_c1_m0_hready", {31'd0, m0_hready_resp}, 32'd0);
      check_val("err_c1_m0_hresp", {30'd0, m0_hresp}, 32'd1);
      check_val("err_c1_m1_hresp", {30'd0, m1_hresp}, 32'd0);
      check_val("err_c1_m1_hready", {31'd0, m1_hready_resp}, 32'd0);
      next_cycle();
      bank(1'b1, 2'b01, 32'h0);
      settle();
      check_val("err_c2_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      check_val("err_c2_m0_hresp", {30'd0, m0_hresp}, 32'd1);
      check_val("err_c2_m1_hresp", {30'd0, m1_hresp}, 32'd0);
      check_val("err_c2_s_haddr", s_haddr, 32'hA00);
      next_cycle();
      m1_drv(1'b0, 2'b00, 1'b0, 32'h0);
      bank(1'b1, 2'b00, 32'h0);
      settle();
      check_val("err_c3_m0_hresp", {30'd0, m0_hresp}, 32'd0);
      check_val("err_c3_m1_hresp", {30'd0, m1_hresp}, 32'd0);
      next_cycle();
      all_idle();
      next_cycle();

      // Reset in the middle of an M1 burst
      m1_drv(1'b1, 2'b10, 1'b1, 32'hB00);
      settle();
      next_cycle();
      m1_drv(1'b1, 2'b11, 1'b1, 32'hB04);
      m1_hwdata = 32'hB0B0_B0B0;
      bank(1'b1, 2'b00, 32'h7777_7777);
      settle();
      check_val("rstb_pre_s_hwdata", s_hwdata, 32'hB0B0_B0B0);
      check_val("rstb_pre_m1_hrdata", m1_hrdata, 32'h7777_7777);
      mem_hrst_b = 1'b0;
      #1;
      check_val("rstb_s_hwdata", s_hwdata, 32'h0);
      check_val("rstb_m1_hrdata", m1_hrdata, 32'h0);
      check_val("rstb_m0_hready", {31'd0, m0_hready_resp}, 32'd1);
      check_val("rstb_m0_hrdata", m0_hrdata, 32'h0);
      all_idle();
      #1;
      check_val("rstb_s_hsel", {31'd0, s_hsel}, 32'd0);
      check_val("rstb_s_htrans", {30'd0, s_htrans}, 32'd0);
      check_val("rstb_arb_idle", {31'd0, arb_idle}, 32'd1);
      check_val("rstb_m1_hready", {31'd0, m1_hready_resp}, 32'd1);
      next_cycle();
      mem_hrst_b = 1'b1;
      next_cycle();
      m1_drv(1'b1, 2'b11, 1'b0, 32'hB08);
      m0_drv(1'b1, 2'b10, 1'b0, 32'hC00);
      settle();
      check_val("post_rst_s_haddr", s_haddr, 32'hC00);
      next_cycle();
      all_idle();
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
